// File: rtl/decryption_sequencer.sv
// Front-end scheduler for the decryption engine bank: routes each message to one
// engine, broadcasts the latched key, holds off upstream while the engine drains, merges outputs.
module decryption_sequencer #(
    parameter int          NUM_ENG = 3,
    parameter int          SEL_W   = 2,
    parameter logic [7:0]  TERM    = 8'hFA,
    parameter int          MAX_LEN = 50,
    parameter int          LEN_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEL_W-1:0]     sel_i,
    input  logic [15:0]          key_i,
    input  logic [7:0]           data_i,
    input  logic                 valid_i,
    output logic                 busy_o,
    output logic [7:0]           eng_data_o,
    output logic [NUM_ENG-1:0]   eng_valid_o,
    output logic [15:0]          eng_key_o,
    input  logic [NUM_ENG-1:0]   eng_busy_i,
    input  logic [NUM_ENG*8-1:0] eng_data_i,
    input  logic [NUM_ENG-1:0]   eng_valid_i,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    output logic                 err_o,
    output logic [LEN_W-1:0]     len_o
);

    typedef enum logic [1:0] {IDLE, ROUTE, DRAIN} state_t;

    // Last non-TERM byte may land at count MAX_LEN-1; the final slot stays free for TERM.
    localparam logic [LEN_W-1:0] CNT_LIMIT = LEN_W'(MAX_LEN - 1);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [15:0]          key_q, key_d;
    logic [7:0]           eng_data_q, eng_data_d;
    logic [NUM_ENG-1:0]   eng_valid_q, eng_valid_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 dwell_q, dwell_d;

    logic [7:0]           sel_byte;
    logic                 sel_vld;
    logic                 sel_bsy;
    logic                 sel_ok;
    logic                 is_term;

    function automatic logic [NUM_ENG-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [NUM_ENG-1:0] v;
        for (int k = 0; k < NUM_ENG; k++) begin
            v[k] = (s == SEL_W'(k));
        end
        return v;
    endfunction

    always_comb begin
        sel_byte = '0;
        sel_vld  = 1'b0;
        sel_bsy  = 1'b0;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_byte = eng_data_i[8*k +: 8];
                sel_vld  = eng_valid_i[k];
                sel_bsy  = eng_busy_i[k];
            end
        end
    end

    assign sel_ok  = (int'(sel_i) < NUM_ENG);
    assign is_term = (data_i == TERM);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        key_d       = key_q;
        eng_data_d  = eng_data_q;
        eng_valid_d = '0;
        err_d       = 1'b0;
        dwell_d     = dwell_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (!sel_ok) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d       = sel_i;
                        key_d       = key_i;
                        eng_data_d  = data_i;
                        eng_valid_d = onehot(sel_i);
                        cnt_d       = LEN_W'(1);
                        dwell_d     = 1'b0;
                        state_d     = is_term ? DRAIN : ROUTE;
                    end
                end
            end
            ROUTE: begin
                if (valid_i) begin
                    if (is_term || (cnt_q < CNT_LIMIT)) begin
                        eng_data_d  = data_i;
                        eng_valid_d = onehot(sel_q);
                        cnt_d       = cnt_q + LEN_W'(1);
                        if (is_term) begin
                            dwell_d = 1'b0;
                            state_d = DRAIN;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // dwell_q marks that one full DRAIN cycle has already elapsed.
                dwell_d = 1'b1;
                if (valid_i && busy_q) begin
                    err_d = 1'b1;
                end
                if (dwell_q && !sel_bsy && !sel_vld) begin
                    len_d   = cnt_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_d  = (state_d == DRAIN);
    assign valid_d = sel_vld;
    assign data_d  = sel_vld ? sel_byte : data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            key_q       <= '0;
            eng_data_q  <= '0;
            eng_valid_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            dwell_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            key_q       <= key_d;
            eng_data_q  <= eng_data_d;
            eng_valid_q <= eng_valid_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            dwell_q     <= dwell_d;
        end
    end

    assign busy_o      = busy_q;
    assign eng_data_o  = eng_data_q;
    assign eng_valid_o = eng_valid_q;
    assign eng_key_o   = key_q;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign err_o       = err_q;
    assign len_o       = len_q;

endmodule

// File: tb/tb_decryption_sequencer.sv
// Directed bench for decryption_sequencer: a message-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_decryption_sequencer;

    localparam int         NUM_ENG = 3;
    localparam logic [7:0] TERM    = 8'hFA;
    localparam int         MAX_LEN = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  sel_i = '0;
    logic [15:0] key_i = '0;
    logic [7:0]  data_i = '0;
    logic        valid_i = 1'b0;
    logic [2:0]  eng_busy_i = '0;
    logic [23:0] eng_data_i = '0;
    logic [2:0]  eng_valid_i = '0;

    logic        busy_o;
    logic [7:0]  eng_data_o;
    logic [2:0]  eng_valid_o;
    logic [15:0] eng_key_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        err_o;
    logic [5:0]  len_o;

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int fwd_seen = 0;
    int out_seen = 0;

    decryption_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .sel_i       (sel_i),
        .key_i       (key_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .busy_o      (busy_o),
        .eng_data_o  (eng_data_o),
        .eng_valid_o (eng_valid_o),
        .eng_key_o   (eng_key_o),
        .eng_busy_i  (eng_busy_i),
        .eng_data_i  (eng_data_i),
        .eng_valid_i (eng_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .err_o       (err_o),
        .len_o       (len_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: tracks the message in flight as plain integers.
    bit          m_in_msg = 0;
    bit          m_draining = 0;
    int          m_age = 0;
    int          m_sel = 0;
    int          m_count = 0;
    logic [15:0] m_key = '0;
    logic [7:0]  m_eng_data = '0;
    logic [2:0]  m_eng_valid = '0;
    logic [7:0]  m_data = '0;
    bit          m_valid = 0;
    bit          m_busy = 0;
    bit          m_err = 0;
    int          m_len_o = 0;

    always @(posedge clk or posedge rst) begin
        int s;
        if (rst) begin
            m_in_msg = 0; m_draining = 0; m_age = 0; m_sel = 0; m_count = 0;
            m_key = '0; m_eng_data = '0; m_eng_valid = '0; m_data = '0;
            m_valid = 0; m_busy = 0; m_err = 0; m_len_o = 0;
        end else begin
            s = m_sel;
            m_valid = eng_valid_i[s];
            if (m_valid) m_data = eng_data_i[8*s +: 8];
            m_err = 0;
            m_eng_valid = '0;
            if (m_draining) begin
                if (valid_i) m_err = 1;
                if (m_age + 1 >= 2 && !eng_busy_i[s] && !eng_valid_i[s]) begin
                    m_draining = 0;
                    m_len_o = m_count;
                    m_count = 0;
                end
                m_age++;
            end else if (m_in_msg) begin
                if (valid_i) begin
                    if (data_i == TERM || m_count < MAX_LEN - 1) begin
                        m_eng_valid = 3'(1 << m_sel);
                        m_eng_data = data_i;
                        m_count++;
                        if (data_i == TERM) begin
                            m_in_msg = 0; m_draining = 1; m_age = 0;
                        end
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (valid_i) begin
                if (int'(sel_i) >= NUM_ENG) begin
                    m_err = 1;
                end else begin
                    m_sel = int'(sel_i);
                    m_key = key_i;
                    m_eng_valid = 3'(1 << m_sel);
                    m_eng_data = data_i;
                    m_count = 1;
                    if (data_i == TERM) begin
                        m_draining = 1; m_age = 0;
                    end else begin
                        m_in_msg = 1;
                    end
                end
            end
            m_busy = m_draining;
        end
    end

    always @(negedge clk) begin
        chk("busy_o",      32'(busy_o),      32'(m_busy));
        chk("eng_valid_o", 32'(eng_valid_o), 32'(m_eng_valid));
        chk("eng_data_o",  32'(eng_data_o),  32'(m_eng_data));
        chk("eng_key_o",   32'(eng_key_o),   32'(m_key));
        chk("valid_o",     32'(valid_o),     32'(m_valid));
        chk("data_o",      32'(data_o),      32'(m_data));
        chk("err_o",       32'(err_o),       32'(m_err));
        chk("len_o",       32'(len_o),       32'(m_len_o));
    end

    always @(negedge clk) begin
        if (err_o) err_seen++;
        if (eng_valid_o != 3'b000) fwd_seen++;
        if (valid_o) out_seen++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] k, input logic [7:0] d);
        @(negedge clk);
        valid_i = v; sel_i = s; key_i = k; data_i = d;
    endtask

    task automatic eng_out(input int k, input logic [7:0] d, input logic v);
        eng_data_i[8*k +: 8] = d;
        eng_valid_i[k] = v;
    endtask

    task automatic clear_counts();
        #1;
        err_seen = 0; fwd_seen = 0; out_seen = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (busy_o) begin
            errors++;
            $display("FAIL wait_idle: busy_o still %0b after %0d cycles, expected 0", busy_o, budget);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},      32'(busy_o),      32'd0);
        chk({tag, "_eng_valid"}, 32'(eng_valid_o), 32'd0);
        chk({tag, "_eng_data"},  32'(eng_data_o),  32'd0);
        chk({tag, "_eng_key"},   32'(eng_key_o),   32'd0);
        chk({tag, "_data"},      32'(data_o),      32'd0);
        chk({tag, "_valid"},     32'(valid_o),     32'd0);
        chk({tag, "_err"},       32'(err_o),       32'd0);
        chk({tag, "_len"},       32'(len_o),       32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        tick(); tick();
        rst = 1'b0;

        // Caesar stream on engine 0 with echoed engine output
        clear_counts();
        drive(1, 2'd0, 16'd3, 8'h44);
        drive(1, 2'd0, 16'd3, 8'h51);
        drive(1, 2'd0, 16'd3, 8'h44);
        drive(1, 2'd0, 16'd3, 8'h41);
        drive(1, 2'd0, 16'd3, TERM);
        tick(); valid_i = 0; eng_busy_i = 3'b001; eng_out(0, 8'h41, 1);
        tick(); eng_out(0, 8'h48, 1);
        tick(); eng_out(0, 8'h5A, 1);
        tick(); eng_out(0, 8'h00, 0); eng_busy_i = 3'b000;
        wait_idle(50);
        chk("t1_len", 32'(len_o), 32'd5);
        chk("t1_key", 32'(eng_key_o), 32'd3);
        chk("t1_fwd", 32'(fwd_seen), 32'd5);
        chk("t1_out", 32'(out_seen), 32'd3);
        chk("t1_data", 32'(data_o), 32'h5A);
        chk("t1_err", 32'(err_seen), 32'd0);

        // Select/key change mid-message; engine 2 output must be ignored
        clear_counts();
        drive(1, 2'd1, 16'd7, 8'h10);
        drive(1, 2'd1, 16'd7, 8'h11);
        drive(1, 2'd2, 16'd9, 8'h12); eng_out(2, 8'hEE, 1);
        drive(1, 2'd2, 16'd9, TERM);
        tick(); valid_i = 0; eng_out(2, 8'h00, 0);
        wait_idle(50);
        chk("t2_len", 32'(len_o), 32'd4);
        chk("t2_key", 32'(eng_key_o), 32'd7);
        chk("t2_fwd", 32'(fwd_seen), 32'd4);
        chk("t2_out", 32'(out_seen), 32'd0);
        chk("t2_data", 32'(data_o), 32'h5A);

        // Overflow: 60 payload bytes, only 49 fit before TERM
        clear_counts();
        for (int i = 0; i < 60; i++) drive(1, 2'd2, 16'h11, 8'(i + 1));
        drive(1, 2'd2, 16'h11, TERM);
        tick(); valid_i = 0;
        wait_idle(50);
        chk("t3_len", 32'(len_o), 32'd50);
        chk("t3_err", 32'(err_seen), 32'd11);
        chk("t3_fwd", 32'(fwd_seen), 32'd50);
        chk("t3_eng_data", 32'(eng_data_o), 32'(TERM));

        // Byte sent while busy is dropped with one error
        clear_counts();
        eng_busy_i = 3'b001;
        drive(1, 2'd0, 16'h22, 8'h41);
        drive(1, 2'd0, 16'h22, TERM);
        drive(1, 2'd0, 16'h22, 8'h41);
        #1 chk("t4_busy", 32'(busy_o), 32'd1);
        tick(); valid_i = 0;
        tick(); tick(); eng_busy_i = 3'b000;
        wait_idle(50);
        chk("t4_err", 32'(err_seen), 32'd1);
        chk("t4_fwd", 32'(fwd_seen), 32'd2);
        chk("t4_len", 32'(len_o), 32'd2);
        clear_counts();
        drive(1, 2'd1, 16'h33, 8'h42);
        drive(1, 2'd1, 16'h33, TERM);
        tick(); valid_i = 0;
        wait_idle(50);
        chk("t4b_len", 32'(len_o), 32'd2);
        chk("t4b_key", 32'(eng_key_o), 32'h33);
        chk("t4b_fwd", 32'(fwd_seen), 32'd2);

        // Out-of-range select
        clear_counts();
        drive(1, 2'd3, 16'h44, 8'h41);
        tick(); valid_i = 0;
        tick(); tick();
        #1;
        chk("t5_err", 32'(err_seen), 32'd1);
        chk("t5_fwd", 32'(fwd_seen), 32'd0);
        chk("t5_busy", 32'(busy_o), 32'd0);
        chk("t5_key", 32'(eng_key_o), 32'h33);

        // Asynchronous reset in the middle of a message
        clear_counts();
        drive(1, 2'd1, 16'h55, 8'h10);
        drive(1, 2'd1, 16'h55, 8'h11);
        tick(); valid_i = 0;
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        tick(); rst = 1'b0;
        drive(1, 2'd0, 16'h66, 8'h20);
        drive(1, 2'd0, 16'h66, 8'h21);
        drive(1, 2'd0, 16'h66, 8'h22);
        drive(1, 2'd0, 16'h66, TERM);
        tick(); valid_i = 0;
        wait_idle(50);
        chk("t6_len", 32'(len_o), 32'd4);
        chk("t6_key", 32'(eng_key_o), 32'h66);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
